lcd_update_scheduler: RTL and testbench

Arbitrates LCD 16x2 redraw requests between several change detectors and sequences them, one at a time, into the LCD write engine. Each detector emits a one-cycle `change` pulse when its monitored field differs from its last value. This block latches those pulses as pending requests and grants them round-robin over a start/done handshake. It also enforces a hold-off gap between LCD transactions, a periodic forced full refresh, and a watchdog on the write engine. It sits between the change detectors and the LCD character-write FSM.

---
 rtl/lcd_sched_pkg.sv | 28 ++
 rtl/lcd_update_scheduler_rr_arbiter.sv | 38 +++
 rtl/lcd_update_scheduler.sv | 139 +++++++++++++
 tb/tb_lcd_update_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_sched_pkg.sv
// lcd_sched_pkg: shared definitions for the LCD update scheduler.
//   state_t     - scheduler FSM encoding (IDLE, WAIT_DONE, HOLDOFF)
//   cnt_width() - bits needed for a counter that runs 0..n-1 (min 1)
//   DEF_*_W     - counter widths for the default parameter values
package lcd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    HOLDOFF   = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_HOLDOFF_CYCLES = 16;
  localparam int DEF_REFRESH_PERIOD = 50_000_000;
  localparam int DEF_TIMEOUT_CYCLES = 100_000;

  localparam int DEF_SEL_W     = $clog2(DEF_NUM_REQ);
  localparam int DEF_HOLDOFF_W = cnt_width(DEF_HOLDOFF_CYCLES);
  localparam int DEF_REFRESH_W = cnt_width(DEF_REFRESH_PERIOD);
  localparam int DEF_TIMEOUT_W = cnt_width(DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/lcd_update_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over a request vector.
//   req       - request bits, one per requester
//   ptr       - index holding highest priority; priority falls ptr, ptr+1, ...
//   gnt_valid - at least one request is set
//   gnt_idx   - chosen requester (0 when gnt_valid is low)
module rr_arbiter
  import lcd_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int SEL_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               gnt_valid,
  output logic [SEL_W-1:0]   gnt_idx
);

  int               pos;
  logic [SEL_W-1:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pos       = 0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Walk from ptr upward with wrap; first set bit wins.
      pos = int'(ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = SEL_W'(pos);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/lcd_update_scheduler.sv
// lcd_update_scheduler: latches change pulses as pending redraw requests and
// issues them one at a time, round-robin, to the LCD write engine.
//   clk, reset   - clock; asynchronous active-high reset
//   change       - one-cycle request pulses, one bit per requester
//   lcd_busy     - engine cannot accept a start this cycle
//   lcd_done     - one-cycle completion pulse from the engine
//   lcd_start    - one-cycle grant pulse; lcd_sel names the requester
//   pending      - latched, not yet granted requests
//   full_refresh - one-cycle pulse when the refresh timer forces all requests
//   err          - sticky: engine failed to return done in time
//   state        - current FSM state, for observation
//
// Handshake: a start is issued only from IDLE with lcd_busy low; lcd_start is
// high for exactly the first WAIT_DONE cycle and lcd_sel is stable from then
// until the next start. lcd_done is honoured only in WAIT_DONE (including the
// cycle lcd_start is high); done beats a simultaneous timeout.
module lcd_update_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int SEL_W         = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] change,
  input  logic               lcd_busy,
  input  logic               lcd_done,
  output logic               lcd_start,
  output logic [SEL_W-1:0]   lcd_sel,
  output logic [NUM_REQ-1:0] pending,
  output logic               full_refresh,
  output logic               err,
  output state_t             state
);

  localparam int RW = cnt_width(REFRESH_PERIOD);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam int HW = cnt_width(HOLDOFF_CYCLES);

  localparam bit REF_EN = (REFRESH_PERIOD > 0);
  localparam bit HO_EN  = (HOLDOFF_CYCLES > 0);

  localparam logic [RW-1:0]    REF_LAST = RW'(REF_EN ? REFRESH_PERIOD - 1 : 0);
  localparam logic [TW-1:0]    TO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [HW-1:0]    HO_LAST  = HW'(HO_EN ? HOLDOFF_CYCLES - 1 : 0);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_REQ - 1);

  state_t             state_next;
  logic [RW-1:0]      refresh_cnt;
  logic [TW-1:0]      to_cnt;
  logic [HW-1:0]      ho_cnt;
  logic [SEL_W-1:0]   ptr;
  logic               gnt_valid;
  logic [SEL_W-1:0]   gnt_idx;
  logic               grant;
  logic               done_hit;
  logic               timeout_hit;
  logic               holdoff_end;
  logic               refresh_fire;
  logic [NUM_REQ-1:0] clr_mask;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (pending),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (grant) state_next = WAIT_DONE;
      WAIT_DONE: if (done_hit || timeout_hit) state_next = HO_EN ? HOLDOFF : IDLE;
      HOLDOFF:   if (holdoff_end) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // FSM-derived controls
  always_comb begin
    grant        = (state == IDLE) && gnt_valid && !lcd_busy;
    done_hit     = (state == WAIT_DONE) && lcd_done;
    timeout_hit  = (state == WAIT_DONE) && !lcd_done && (to_cnt == TO_LAST);
    holdoff_end  = (state == HOLDOFF) && (ho_cnt == HO_LAST);
    refresh_fire = REF_EN && (refresh_cnt == REF_LAST);
    clr_mask     = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

  // Counters: timeout and holdoff restart on every entry to their state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      to_cnt      <= '0;
      ho_cnt      <= '0;
    end else begin
      if (!REF_EN || refresh_fire) refresh_cnt <= '0;
      else                         refresh_cnt <= refresh_cnt + 1'b1;

      if (state == WAIT_DONE && state_next == WAIT_DONE) to_cnt <= to_cnt + 1'b1;
      else                                               to_cnt <= '0;

      if (state == HOLDOFF && state_next == HOLDOFF) ho_cnt <= ho_cnt + 1'b1;
      else                                           ho_cnt <= '0;
    end
  end

  // Pending, pointer and registered outputs. Sets are ORed after the grant
  // clear so a change pulse on the grant edge re-queues the same requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending      <= '0;
      ptr          <= '0;
      lcd_start    <= 1'b0;
      lcd_sel      <= '0;
      full_refresh <= 1'b0;
      err          <= 1'b0;
    end else begin
      pending      <= (pending & ~clr_mask) | change | {NUM_REQ{refresh_fire}};
      lcd_start    <= grant;
      full_refresh <= refresh_fire;
      err          <= err | timeout_hit;
      if (grant) begin
        lcd_sel <= gnt_idx;
        ptr     <= (gnt_idx == SEL_LAST) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_update_scheduler.sv
// tb_lcd_update_scheduler: directed bench for lcd_update_scheduler.
// dut_a (HOLDOFF=4, no refresh, long timeout) covers latency, fairness,
// re-queue, busy and async reset; dut_b (HOLDOFF=4, REFRESH=100, TIMEOUT=8)
// covers the forced refresh, busy hold and watchdog. Expected grant indices
// are queued when requests are driven and popped at each observed start.
module tb_lcd_update_scheduler;
  import lcd_sched_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] change_a, change_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic       start_a, start_b, fr_a, fr_b, err_a, err_b;
  logic [1:0] sel_a, sel_b;
  logic [3:0] pend_a, pend_b;
  state_t     state_a, state_b;

  logic       use_b;
  logic       cur_start;
  logic [1:0] cur_sel;

  logic [31:0] exp_q[$];
  int          errors;
  int          checks;
  int          w;

  lcd_update_scheduler #(
    .NUM_REQ(4), .HOLDOFF_CYCLES(4), .REFRESH_PERIOD(0), .TIMEOUT_CYCLES(64)
  ) dut_a (
    .clk(clk), .reset(reset), .change(change_a), .lcd_busy(busy_a),
    .lcd_done(done_a), .lcd_start(start_a), .lcd_sel(sel_a),
    .pending(pend_a), .full_refresh(fr_a), .err(err_a), .state(state_a)
  );

  lcd_update_scheduler #(
    .NUM_REQ(4), .HOLDOFF_CYCLES(4), .REFRESH_PERIOD(100), .TIMEOUT_CYCLES(8)
  ) dut_b (
    .clk(clk), .reset(reset), .change(change_b), .lcd_busy(busy_b),
    .lcd_done(done_b), .lcd_start(start_b), .lcd_sel(sel_b),
    .pending(pend_b), .full_refresh(fr_b), .err(err_b), .state(state_b)
  );

  assign cur_start = use_b ? start_b : start_a;
  assign cur_sel   = use_b ? sel_b   : sel_a;

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_change(input logic [3:0] bits);
    change_a = bits;
    step();
    change_a = '0;
  endtask

  task automatic pulse_done();
    if (use_b) done_b = 1'b1; else done_a = 1'b1;
    step();
    done_a = 1'b0;
    done_b = 1'b0;
  endtask

  // Waits (checking before each step) for lcd_start, then checks the granted
  // index against the scoreboard. waited = steps taken.
  task automatic wait_start(input string tag, input int budget, output int waited);
    logic [31:0] exp;
    waited = 0;
    while (!cur_start && waited < budget) begin
      step();
      waited++;
    end
    chk({tag, "_start"}, {31'd0, cur_start}, 32'd1);
    if (cur_start) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead;
      chk({tag, "_sel"}, {30'd0, cur_sel}, exp);
    end
  endtask

  task automatic expect_no_start(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      step();
      if (cur_start) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    errors = 0; checks = 0; use_b = 1'b0;
    reset = 1'b1;
    change_a = '0; change_b = '0;
    busy_a = 1'b0; busy_b = 1'b1;
    done_a = 1'b0; done_b = 1'b0;

    // Reset state
    repeat (2) step();
    chk("rst_outs_a", {start_a, fr_a, err_a, sel_a, pend_a}, 32'd0);
    chk("rst_outs_b", {start_b, fr_b, err_b, sel_b, pend_b}, 32'd0);
    chk("rst_state_a", 32'(state_a), 32'(IDLE));
    reset = 1'b0;
    step();

    // Single request: pending next cycle, start one edge later on sel 2
    pulse_change(4'b0100);
    exp_q.push_back(2);
    chk("single_pend", {28'd0, pend_a}, 32'h4);
    chk("single_nostart", {31'd0, start_a}, 32'd0);
    wait_start("single", 5, w);
    chk("single_lat", w, 1);
    chk("single_clr", {28'd0, pend_a}, 32'h0);
    step();
    chk("start_width", {31'd0, start_a}, 32'd0);
    pulse_change(4'b1000);
    exp_q.push_back(3);
    repeat (7) step();
    chk("sel_hold", {30'd0, sel_a}, 32'd2);
    chk("queued_pend", {28'd0, pend_a}, 32'h8);
    pulse_done();
    wait_start("after_done", 20, w);
    chk("holdoff_gap", w, 5);
    pulse_done();
    repeat (4) step();
    chk("idle_again", 32'(state_a), 32'(IDLE));

    // Fairness: all four, then 0 and 3
    pulse_change(4'b1111);
    for (int k = 0; k < 4; k++) exp_q.push_back(k);
    for (int k = 0; k < 4; k++) begin
      wait_start("fair", 20, w);
      repeat (2) step();
      pulse_done();
    end
    expect_no_start("fair_extra", 12);
    pulse_change(4'b1001);
    exp_q.push_back(0);
    exp_q.push_back(3);
    for (int k = 0; k < 2; k++) begin
      wait_start("fair2", 20, w);
      repeat (2) step();
      pulse_done();
    end
    repeat (4) step();

    // Busy hold, then re-queue collision on requester 1
    busy_a = 1'b1;
    pulse_change(4'b0010);
    exp_q.push_back(1);
    expect_no_start("busy_a", 5);
    busy_a = 1'b0;
    change_a = 4'b0010;
    exp_q.push_back(1);
    step();
    change_a = '0;
    wait_start("requeue", 1, w);
    chk("requeue_lat", w, 0);
    chk("requeue_pend", {28'd0, pend_a}, 32'h2);
    repeat (2) step();
    pulse_done();
    wait_start("requeue2", 20, w);
    repeat (2) step();
    pulse_done();
    repeat (4) step();

    // Async reset mid-cycle in WAIT_DONE with start high and a pending bit
    busy_a = 1'b1;
    pulse_change(4'b1100);
    busy_a = 1'b0;
    exp_q.push_back(2);
    wait_start("rst_grant", 5, w);
    chk("rst_pre_pend", {28'd0, pend_a}, 32'h8);
    #2 reset = 1'b1;
    #1;
    chk("async_start", {31'd0, start_a}, 32'd0);
    chk("async_pend", {28'd0, pend_a}, 32'h0);
    chk("async_misc", {err_a, sel_a}, 32'd0);
    chk("async_state", 32'(state_a), 32'(IDLE));
    exp_q.delete();
    repeat (2) step();
    reset = 1'b0;
    pulse_done();
    chk("done_ignored", 32'(state_a), 32'(IDLE));
    expect_no_start("post_rst", 9);

    // dut_b: refresh at cycle 100 while busy, then watchdog
    use_b = 1'b1;
    w = 0;
    while (!fr_b && w < 200) begin
      step();
      w++;
    end
    chk("refresh_at", w + 10, 100);
    chk("refresh_pend", {28'd0, pend_b}, 32'hf);
    step();
    chk("refresh_width", {31'd0, fr_b}, 32'd0);
    expect_no_start("busy_b", 20);
    for (int k = 0; k < 4; k++) exp_q.push_back(k);
    busy_b = 1'b0;
    wait_start("b_grant", 5, w);
    chk("b_grant_lat", w, 1);
    w = 0;
    while (!err_b && w < 20) begin
      step();
      w++;
    end
    chk("err_at", w, 8);
    chk("to_state", 32'(state_b), 32'(HOLDOFF));
    wait_start("after_to", 20, w);
    chk("after_to_gap", w, 5);
    for (int k = 0; k < 2; k++) begin
      repeat (2) step();
      pulse_done();
      wait_start("b_rest", 20, w);
    end
    repeat (2) step();
    pulse_done();
    repeat (5) step();
    chk("b_pend_empty", {28'd0, pend_b}, 32'h0);
    chk("err_sticky", {31'd0, err_b}, 32'd1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
